// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
//   Load/store unit for the pipeline memory stage. Converts execute-stage
//   load/store requests into word-indexed data-memory accesses. Byte and
//   halfword stores become a two-cycle read-modify-write, because the data
//   memory only writes whole words. Load results are extracted from the
//   addressed lane and then sign- or zero-extended. Misaligned, out-of-range
//   and illegal requests are rejected with a one-cycle fault pulse.
//
// Ports
//   clk         pipeline clock, rising edge
//   reset       asynchronous active-low reset
//   req_valid   request present in the memory stage
//   req_load    request is a load
//   req_store   request is a store
//   funct3      RV32I width code (0=B, 1=H, 2=W, 4=BU, 5=HU)
//   addr        byte address from the ALU
//   store_data  rs2 value (low byte/halfword used for SB/SH)
//   mem_rdata   combinational read data from the data memory
//   mem_addr    word index to the data memory
//   mem_wdata   write word (0 when mem_wr_en is low)
//   mem_wr_en   memory write enable
//   mem_rd_en   memory read enable
//   stall       hold upstream stages; the request must be held unchanged
//   resp_valid  registered one-cycle pulse; load_data is valid
//   load_data   registered, extended load result
//   fault       registered one-cycle pulse; the request was rejected
// -----------------------------------------------------------------------------
module lsu_mem_stage #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        fault
);

  // Word-index width; for the default 32 words the index is addr[6:2].
  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_MERGE = 1'b1;

  logic [0:0]       state_q;
  logic [31:0]      merge_word_q;
  logic [IDX_W-1:0] merge_idx_q;

  logic [IDX_W-1:0] word_idx;
  logic             is_byte;
  logic             is_half;
  logic             is_word;
  logic             bad_width;
  logic             out_of_range;
  logic             misaligned;
  logic             req_bad;
  logic             idle_req;
  logic             accept;
  logic             do_load;
  logic             do_sub_store;
  logic             in_merge;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [31:0]      load_ext;
  logic [31:0]      merged_word;

  assign word_idx = addr[IDX_W+1:2];

  // Width decode ignores funct3[2] (the unsigned bit); illegal codes are
  // caught separately by bad_width.
  assign is_byte = (funct3[1:0] == 2'd0);
  assign is_half = (funct3[1:0] == 2'd1);
  assign is_word = (funct3[1:0] == 2'd2);

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    bad_width = 1'b0;
    if (req_load)
      bad_width = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    else if (req_store)
      bad_width = (funct3 >= 3'd3);
  end

  assign out_of_range = |addr[31:IDX_W+2];
  assign misaligned   = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'd0));
  assign req_bad      = (req_load && req_store) || out_of_range || bad_width || misaligned;

  // Reset gating keeps the memory enables and stall low while reset is held,
  // including the abandoned write of a MERGE cycle.
  assign idle_req     = reset && (state_q == ST_IDLE) && req_valid && (req_load || req_store);
  assign accept       = idle_req && !req_bad;
  assign do_load      = accept && req_load;
  assign do_sub_store = accept && req_store && !is_word;
  assign in_merge     = reset && (state_q == ST_MERGE);

  // Load lane extraction and extension.
  always_comb begin
    lane_byte = 8'h00;
    case (addr[1:0])
      2'd0: lane_byte = mem_rdata[7:0];
      2'd1: lane_byte = mem_rdata[15:8];
      2'd2: lane_byte = mem_rdata[23:16];
      2'd3: lane_byte = mem_rdata[31:24];
      default: lane_byte = 8'h00;
    endcase
    lane_half = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_ext = mem_rdata;
    if (is_byte)
      load_ext = funct3[2] ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
    else if (is_half)
      load_ext = funct3[2] ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
  end

  // Read-modify-write merge: replace the addressed lane of the current word.
  always_comb begin
    merged_word = mem_rdata;
    if (is_byte) begin
      case (addr[1:0])
        2'd0: merged_word[7:0]   = store_data[7:0];
        2'd1: merged_word[15:8]  = store_data[7:0];
        2'd2: merged_word[23:16] = store_data[7:0];
        2'd3: merged_word[31:24] = store_data[7:0];
        default: merged_word = mem_rdata;
      endcase
    end else if (addr[1]) begin
      merged_word[31:16] = store_data[15:0];
    end else begin
      merged_word[15:0]  = store_data[15:0];
    end
  end

  // Memory-side outputs.
  always_comb begin
    mem_addr  = {{(32-IDX_W){1'b0}}, word_idx};
    mem_wdata = 32'h0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    stall     = 1'b0;
    if (in_merge) begin
      mem_addr  = {{(32-IDX_W){1'b0}}, merge_idx_q};
      mem_wdata = merge_word_q;
      mem_wr_en = 1'b1;
    end else if (do_load) begin
      mem_rd_en = 1'b1;
    end else if (accept && req_store && is_word) begin
      mem_wdata = store_data;
      mem_wr_en = 1'b1;
    end else if (do_sub_store) begin
      mem_rd_en = 1'b1;
      stall     = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the merge word/index registers are reset too, so the MERGE path
  // never drives an undefined word after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      merge_word_q <= 32'h0;
      merge_idx_q  <= '0;
      resp_valid   <= 1'b0;
      load_data    <= 32'h0;
      fault        <= 1'b0;
    end else begin
      resp_valid <= do_load;
      fault      <= idle_req && req_bad;
      if (do_load)
        load_data <= load_ext;
      if (state_q == ST_MERGE) begin
        state_q <= ST_IDLE;
      end else if (do_sub_store) begin
        merge_word_q <= merged_word;
        merge_idx_q  <= word_idx;
        state_q      <= ST_MERGE;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_stage
//   Directed bench for lsu_mem_stage. A small behavioural word memory sits
//   behind the unit; a table of per-cycle vectors carries both stimulus and
//   hand-computed expected outputs. Reset during MERGE is a hand sequence.
// -----------------------------------------------------------------------------
module tb_lsu_mem_stage;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_load;
  logic        req_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic        stall;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  lsu_mem_stage #(.MEM_WORDS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_load   (req_load),
    .req_store  (req_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr_en  (mem_wr_en),
    .mem_rd_en  (mem_rd_en),
    .stall      (stall),
    .resp_valid (resp_valid),
    .load_data  (load_data),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write at the rising edge.
  logic [31:0] mem [32];
  assign mem_rdata = mem[mem_addr[4:0]];
  always @(posedge clk) begin
    if (mem_wr_en)
      mem[mem_addr[4:0]] <= mem_wdata;
  end

  typedef struct {
    string       name;
    logic        valid;
    logic        load;
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        rd;
    logic        wr;
    logic        stl;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic        resp;
    logic        flt;
    logic [31:0] ldata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic v, input logic ld, input logic st,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                     input logic rd, input logic wr, input logic stl,
                     input logic [31:0] maddr, input logic [31:0] wd,
                     input logic resp, input logic flt, input logic [31:0] ldata);
    vec_t t;
    t.name = name; t.valid = v; t.load = ld; t.store = st; t.f3 = f3;
    t.addr = a; t.sdata = sd; t.rd = rd; t.wr = wr; t.stl = stl;
    t.maddr = maddr; t.wdata = wd; t.resp = resp; t.flt = flt; t.ldata = ldata;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    req_valid = v; req_load = ld; req_store = st; funct3 = f3; addr = a; store_data = sd;
  endtask

  // Inputs change 1 time unit after the rising edge; combinational outputs
  // are sampled at the falling edge, registered outputs 1 unit after the
  // next rising edge.
  task automatic run_vec(input vec_t t);
    drive(t.valid, t.load, t.store, t.f3, t.addr, t.sdata);
    @(negedge clk);
    check({t.name, " rd_en"},  {31'h0, mem_rd_en}, {31'h0, t.rd});
    check({t.name, " wr_en"},  {31'h0, mem_wr_en}, {31'h0, t.wr});
    check({t.name, " stall"},  {31'h0, stall},     {31'h0, t.stl});
    check({t.name, " mem_addr"},  mem_addr,  t.maddr);
    check({t.name, " mem_wdata"}, mem_wdata, t.wdata);
    @(posedge clk); #1;
    check({t.name, " resp_valid"}, {31'h0, resp_valid}, {31'h0, t.resp});
    check({t.name, " fault"},      {31'h0, fault},      {31'h0, t.flt});
    check({t.name, " load_data"},  load_data,           t.ldata);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'd2, 32'h4, 32'hDEADBEEF);

    // Outputs stay quiet while reset is held, even with a store presented.
    @(negedge clk);
    check("rst wr_en", {31'h0, mem_wr_en}, 32'h0);
    check("rst rd_en", {31'h0, mem_rd_en}, 32'h0);
    check("rst stall", {31'h0, stall}, 32'h0);
    check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst fault", {31'h0, fault}, 32'h0);
    check("rst load_data", load_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    //   name        v  ld st f3    addr     sdata          rd wr st maddr wdata          rsp flt ldata
    add("sw",        1, 0, 1, 3'd2, 32'h04, 32'h8899AABB,  0, 1, 0, 32'd1, 32'h8899AABB,  0,  0, 32'h0);
    add("lw",        1, 1, 0, 3'd2, 32'h04, 32'h0,         1, 0, 0, 32'd1, 32'h0,         1,  0, 32'h8899AABB);
    add("lb",        1, 1, 0, 3'd0, 32'h05, 32'h0,         1, 0, 0, 32'd1, 32'h0,         1,  0, 32'hFFFFFFAA);
    add("lbu",       1, 1, 0, 3'd4, 32'h07, 32'h0,         1, 0, 0, 32'd1, 32'h0,         1,  0, 32'h00000088);
    add("lh",        1, 1, 0, 3'd1, 32'h06, 32'h0,         1, 0, 0, 32'd1, 32'h0,         1,  0, 32'hFFFF8899);
    add("lhu",       1, 1, 0, 3'd5, 32'h04, 32'h0,         1, 0, 0, 32'd1, 32'h0,         1,  0, 32'h0000AABB);
    add("sb rd",     1, 0, 1, 3'd0, 32'h06, 32'h12,        1, 0, 1, 32'd1, 32'h0,         0,  0, 32'h0000AABB);
    // MERGE cycle: a different request is presented and must be ignored.
    add("sb merge",  1, 1, 0, 3'd2, 32'h10, 32'h0,         0, 1, 0, 32'd1, 32'h8812AABB,  0,  0, 32'h0000AABB);
    add("lw merged", 1, 1, 0, 3'd2, 32'h04, 32'h0,         1, 0, 0, 32'd1, 32'h0,         1,  0, 32'h8812AABB);
    add("sh mis",    1, 0, 1, 3'd1, 32'h05, 32'hBEEF,      0, 0, 0, 32'd1, 32'h0,         0,  1, 32'h8812AABB);
    add("lw mis",    1, 1, 0, 3'd2, 32'h06, 32'h0,         0, 0, 0, 32'd1, 32'h0,         0,  1, 32'h8812AABB);
    add("lb oor",    1, 1, 0, 3'd0, 32'h80, 32'h0,         0, 0, 0, 32'd0, 32'h0,         0,  1, 32'h8812AABB);
    add("ld f3=3",   1, 1, 0, 3'd3, 32'h04, 32'h0,         0, 0, 0, 32'd1, 32'h0,         0,  1, 32'h8812AABB);
    add("st f3=4",   1, 0, 1, 3'd4, 32'h04, 32'h0,         0, 0, 0, 32'd1, 32'h0,         0,  1, 32'h8812AABB);
    add("ld+st",     1, 1, 1, 3'd2, 32'h04, 32'h0,         0, 0, 0, 32'd1, 32'h0,         0,  1, 32'h8812AABB);
    add("idle",      0, 1, 0, 3'd2, 32'h04, 32'h0,         0, 0, 0, 32'd1, 32'h0,         0,  0, 32'h8812AABB);
    add("lw after",  1, 1, 0, 3'd2, 32'h04, 32'h0,         1, 0, 0, 32'd1, 32'h0,         1,  0, 32'h8812AABB);
    add("sh hi",     1, 0, 1, 3'd1, 32'h0A, 32'h1234,      1, 0, 1, 32'd2, 32'h0,         0,  0, 32'h8812AABB);
    add("sh merge",  0, 0, 0, 3'd0, 32'h00, 32'h0,         0, 1, 0, 32'd2, 32'h12340000,  0,  0, 32'h8812AABB);
    add("lh word2",  1, 1, 0, 3'd1, 32'h0A, 32'h0,         1, 0, 0, 32'd2, 32'h0,         1,  0, 32'h00001234);

    foreach (vecs[i]) run_vec(vecs[i]);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(posedge clk); #1;

    // Reset during MERGE: the write is abandoned and memory keeps its value.
    drive(1'b1, 1'b0, 1'b1, 3'd1, 32'h04, 32'hBEEF);
    @(negedge clk);
    check("shrst stall", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    check("shrst wr_en", {31'h0, mem_wr_en}, 32'h0);
    check("shrst rd_en", {31'h0, mem_rd_en}, 32'h0);
    check("shrst wdata", mem_wdata, 32'h0);
    check("shrst resp_valid", {31'h0, resp_valid}, 32'h0);
    check("shrst fault", {31'h0, fault}, 32'h0);
    check("shrst load_data", load_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    check("shrst mem word1", mem[1], 32'h8812AABB);

    // Unit must be back in IDLE: a load is accepted immediately.
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h04, 32'h0);
    @(negedge clk);
    check("post rst rd_en", {31'h0, mem_rd_en}, 32'h1);
    check("post rst wr_en", {31'h0, mem_wr_en}, 32'h0);
    check("post rst stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    check("post rst resp_valid", {31'h0, resp_valid}, 32'h1);
    check("post rst load_data", load_data, 32'h8812AABB);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("post rst resp drop", {31'h0, resp_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the pipeline's memory stage. It sits directly upstream of the data memory and turns execute-stage load/store requests into word-indexed memory accesses. It performs sub-word (byte/halfword) stores as a two-cycle read-modify-write, because the data memory only writes whole words. It sign- or zero-extends load results and flags misaligned, out-of-range and illegal accesses.

## Interface
Parameters:
- `MEM_WORDS`, default 32: number of data-memory words. The word index is `addr[6:2]`.

Ports:
- `clk`  input  1  pipeline clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  memory-stage request present.
- `req_load`  input  1  request is a load.
- `req_store`  input  1  request is a store.
- `funct3`  input  3  RV32I width code: 0=B, 1=H, 2=W, 4=BU, 5=HU.
- `addr`  input  32  byte address from the ALU.
- `store_data`  input  32  rs2 value; the low byte or halfword is used for SB/SH.
- `mem_rdata`  input  32  combinational read data from the data memory.
- `mem_addr`  output  32  word index to memory, `{27'b0, addr[6:2]}`.
- `mem_wdata`  output  32  write word.
- `mem_wr_en`  output  1  memory write enable.
- `mem_rd_en`  output  1  memory read enable.
- `stall`  output  1  hold upstream stages; the request must be held unchanged.
- `resp_valid`  output  1  registered one-cycle pulse; `load_data` is valid.
- `load_data`  output  32  extended load result, registered.
- `fault`  output  1  registered one-cycle pulse; the request was rejected.

## Operation
- State machine has two states, IDLE and MERGE. It resets to IDLE.
- Fault check, in IDLE with `req_valid`. A request faults on any of:
  - `req_load` and `req_store` both high;
  - `addr[31:7]` is nonzero;
  - load `funct3` is 3, 6 or 7;
  - store `funct3` is 3 or higher;
  - H/HU access with `addr[0]` = 1;
  - W access with `addr[1:0]` nonzero.
- A faulting request asserts no memory enable. `fault` pulses on the next cycle.
- Load (IDLE): `mem_rd_en`=1 combinationally. At the clock edge:
  - the byte at lane `addr[1:0]` or the halfword at lane `addr[1]` is extracted from `mem_rdata`;
  - it is sign-extended (B/H), zero-extended (BU/HU) or passed through (W) into `load_data`;
  - `resp_valid` is set.
- SW (IDLE): `mem_wr_en`=1 and `mem_wdata`=`store_data` in the same cycle. The write occurs at that edge. No stall.
- SB/SH (IDLE): `mem_rd_en`=1 and `stall`=1 combinationally. At the edge the unit:
  - latches the merged word (`mem_rdata` with the addressed lane replaced by `store_data[7:0]` or `[15:0]`);
  - latches the word index;
  - moves to MERGE.
- MERGE: `mem_wr_en`=1, `mem_wdata`=latched merged word, `mem_addr`=latched index, `stall`=0. Request inputs are ignored. Next state is IDLE, and the request counts as retired.
- `mem_wdata` is 0 whenever `mem_wr_en`=0. The two memory enables are never high together.
- `req_valid`=0 in IDLE: no enables, no pulses.

## Timing
- Reset values: state IDLE, `resp_valid`=0, `fault`=0, `load_data`=0, latched merge word/index 0. `mem_wr_en`, `mem_rd_en` and `stall` are 0 while reset is asserted.
- Load latency is 1 cycle: request at cycle N gives `resp_valid`/`load_data` at N+1. Back-to-back loads run at 1 per cycle.
- SW takes 1 cycle. SB/SH takes 2 cycles with `stall` high only in the first. The next request is accepted in the cycle after MERGE.
- A load directly after an SB/SH to the same word observes the merged value, since the write commits at the end of MERGE.
- Reset asserted during MERGE: the write is abandoned, the state returns to IDLE and memory is unchanged by the unit.
- `resp_valid` and `fault` are never high in the same cycle. `load_data` holds its last value when `resp_valid`=0.

## Test plan
- Reset, then SW 0x8899AABB to addr 0x04 -> `mem_wr_en`=1 and `mem_addr`=1 in the same cycle. A following LW 0x04 gives `resp_valid`=1 and `load_data`=0x8899AABB one cycle later.
- LB 0x05 -> 0xFFFFFFAA. LBU 0x07 -> 0x00000088. LH 0x06 -> 0xFFFF8899. LHU 0x04 -> 0x0000AABB. Issued back-to-back with four consecutive `resp_valid` pulses.
- SB 0x12 to 0x06 -> `stall`=1 for one cycle with `mem_rd_en`=1, then `mem_wr_en`=1 with `mem_wdata`=0x8812AABB. An immediate LW 0x04 returns 0x8812AABB.
- SH to 0x05, LW from 0x06, LB from 0x80 and funct3=3 load -> each gives a one-cycle `fault` with no memory enables; memory word 1 unchanged.
- SH 0xBEEF to 0x04 with reset asserted in the MERGE cycle -> no `mem_wr_en`, state IDLE, all outputs 0. LW 0x04 after reset returns the prior value 0x8812AABB.
